// File: rtl/cdc_sync_param.sv
// -----------------------------------------------------------------------------
// cdc_sync_param
//   Collects every asynchronous input that feeds the HF_CLK domain and brings
//   each one in safely:
//     - a reset synchroniser (asynchronous assert, synchronous deassert)
//     - N_LEVEL single-bit level synchronisers
//     - N_EVENT toggle-to-pulse event channels
//     - a configuration bus that is committed only after it has been seen
//       stable for STABLE_CYC consecutive samples (qualifier FSM)
//
// Ports
//   HF_CLK        in   destination clock
//   NRST          in   asynchronous active-low reset
//   LEVEL_IN      in   [N_LEVEL]  asynchronous levels
//   EVENT_TGL_IN  in   [N_EVENT]  asynchronous event toggles (1 toggle = 1 event)
//   BUS_IN        in   [BUS_W]    asynchronous configuration bus
//   BUS_LOAD_TGL  in   toggle requesting a bus update
//   HOLD          in   HF_CLK domain, high defers the commit
//   CLR_ERR       in   HF_CLK domain pulse, clears BUS_ERR
//   NRST_sync     out  synchronised reset
//   LEVEL_sync    out  [N_LEVEL]  synchronised levels
//   EVENT_PULSE   out  [N_EVENT]  one-cycle pulse per input toggle
//   BUS_sync      out  [BUS_W]    committed bus
//   BUS_UPDATED   out  one-cycle pulse on each commit
//   BUS_BUSY      out  qualifier FSM not idle
//   BUS_ERR       out  sticky abort flag (too many bus changes)
// -----------------------------------------------------------------------------
module cdc_sync_param #(
    parameter int               SYNC_STAGES = 2,
    parameter int               N_LEVEL     = 4,
    parameter int               N_EVENT     = 2,
    parameter int               BUS_W       = 38,
    parameter logic [BUS_W-1:0] BUS_RST     = '0,
    parameter int               STABLE_CYC  = 4,
    parameter int               MAX_RETRY   = 7
) (
    input  logic               HF_CLK,
    input  logic               NRST,
    input  logic [N_LEVEL-1:0] LEVEL_IN,
    input  logic [N_EVENT-1:0] EVENT_TGL_IN,
    input  logic [BUS_W-1:0]   BUS_IN,
    input  logic               BUS_LOAD_TGL,
    input  logic               HOLD,
    input  logic               CLR_ERR,
    output logic               NRST_sync,
    output logic [N_LEVEL-1:0] LEVEL_sync,
    output logic [N_EVENT-1:0] EVENT_PULSE,
    output logic [BUS_W-1:0]   BUS_sync,
    output logic               BUS_UPDATED,
    output logic               BUS_BUSY,
    output logic               BUS_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUAL,
        ST_WAIT_HOLD,
        ST_COMMIT
    } state_t;

    localparam logic [3:0] CNT_LAST  = 4'(STABLE_CYC - 1);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

    // Synchroniser chains: index 0 is the metastable first stage.
    logic [SYNC_STAGES-1:0]              r_rst_meta;
    logic [SYNC_STAGES-1:0][N_LEVEL-1:0] r_lvl_meta;
    logic [SYNC_STAGES-1:0][N_EVENT-1:0] r_evt_meta;
    logic [N_EVENT-1:0]                  r_evt_hist;
    logic [SYNC_STAGES-1:0][BUS_W-1:0]   r_bus_meta;
    logic [SYNC_STAGES-1:0]              r_load_meta;
    logic                                r_load_hist;

    // Qualifier FSM state
    state_t           r_state;
    logic [BUS_W-1:0] r_sample;
    logic [3:0]       r_cnt;
    logic [3:0]       r_retry;
    logic             r_pending;
    logic [BUS_W-1:0] r_bus_sync;
    logic             r_bus_updated;
    logic             r_bus_err;

    logic [BUS_W-1:0] w_bus_s;
    logic             w_req;
    logic [3:0]       w_retry_nxt;

    // Reset synchroniser: shifts ones in after NRST rises, so the output
    // deasserts on the SYNC_STAGES-th edge, but asserts with no clock at all.
    always_ff @(posedge HF_CLK or negedge NRST) begin
        if (!NRST) begin
            r_rst_meta <= '0;
        end else begin
            // NOTE: non-blocking assignment keeps every stage sampling the
            // pre-edge value of its predecessor, which is what makes a chain.
            r_rst_meta <= {r_rst_meta[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge HF_CLK or negedge NRST) begin
        if (!NRST) begin
            r_lvl_meta  <= '0;
            r_evt_meta  <= '0;
            r_evt_hist  <= '0;
            r_bus_meta  <= '0;
            r_load_meta <= '0;
            r_load_hist <= 1'b0;
        end else begin
            r_lvl_meta  <= {r_lvl_meta[SYNC_STAGES-2:0], LEVEL_IN};
            r_evt_meta  <= {r_evt_meta[SYNC_STAGES-2:0], EVENT_TGL_IN};
            r_evt_hist  <= r_evt_meta[SYNC_STAGES-1];
            r_bus_meta  <= {r_bus_meta[SYNC_STAGES-2:0], BUS_IN};
            r_load_meta <= {r_load_meta[SYNC_STAGES-2:0], BUS_LOAD_TGL};
            r_load_hist <= r_load_meta[SYNC_STAGES-1];
        end
    end

    // The bus bits may be skewed through the chain; the FSM below only
    // trusts bus_s once it has stopped changing for STABLE_CYC samples.
    assign w_bus_s     = r_bus_meta[SYNC_STAGES-1];
    assign w_req       = r_load_meta[SYNC_STAGES-1] ^ r_load_hist;
    assign w_retry_nxt = r_retry + 4'd1;

    always_ff @(posedge HF_CLK or negedge NRST) begin
        if (!NRST) begin
            r_state       <= ST_IDLE;
            r_sample      <= '0;
            r_cnt         <= '0;
            r_retry       <= '0;
            r_pending     <= 1'b0;
            r_bus_sync    <= BUS_RST;
            r_bus_updated <= 1'b0;
            r_bus_err     <= 1'b0;
        end else begin
            r_bus_updated <= 1'b0;
            if (CLR_ERR) begin
                r_bus_err <= 1'b0;
            end
            // Requests arriving while busy coalesce into a single pending flag.
            if (w_req && (r_state != ST_IDLE)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_req || r_pending) begin
                        r_sample  <= w_bus_s;
                        r_cnt     <= 4'd1;
                        r_retry   <= '0;
                        r_pending <= 1'b0;
                        r_state   <= ST_QUAL;
                    end
                end
                ST_QUAL: begin
                    if (w_bus_s == r_sample) begin
                        if (r_cnt == CNT_LAST) begin
                            r_state <= HOLD ? ST_WAIT_HOLD : ST_COMMIT;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else begin
                        r_sample <= w_bus_s;
                        r_cnt    <= 4'd1;
                        r_retry  <= w_retry_nxt;
                        // Later assignment wins over CLR_ERR above: abort has priority.
                        if (w_retry_nxt == RETRY_MAX) begin
                            r_bus_err <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_HOLD: begin
                    if (!HOLD) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_bus_sync    <= r_sample;
                    r_bus_updated <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign NRST_sync   = r_rst_meta[SYNC_STAGES-1];
    assign LEVEL_sync  = r_lvl_meta[SYNC_STAGES-1];
    assign EVENT_PULSE = r_evt_meta[SYNC_STAGES-1] ^ r_evt_hist;
    assign BUS_sync    = r_bus_sync;
    assign BUS_UPDATED = r_bus_updated;
    assign BUS_BUSY    = (r_state != ST_IDLE);
    assign BUS_ERR     = r_bus_err;

endmodule

// File: doc/cdc_sync_param.md
CDC_SYNC_PARAM -- requirements
Module: cdc_sync_param

Parameters
REQ-001 The block SHALL provide parameter SYNC_STAGES, default 2, range 2..4: flop depth of every synchroniser chain.
REQ-002 The block SHALL provide parameter N_LEVEL, default 4: number of single-bit level channels.
REQ-003 The block SHALL provide parameter N_EVENT, default 2: number of toggle-to-pulse event channels.
REQ-004 The block SHALL provide parameter BUS_W, default 38: width of the qualified configuration bus.
REQ-005 The block SHALL provide parameter BUS_RST, default 0, width BUS_W: reset value of BUS_sync.
REQ-006 The block SHALL provide parameter STABLE_CYC, default 4, range 2..15: consecutive equal bus samples required before commit.
REQ-007 The block SHALL provide parameter MAX_RETRY, default 7, range 1..15: bus mismatches tolerated per request before abort.

Interface
REQ-008 HF_CLK  in  1  single destination clock.
REQ-009 NRST  in  1  asynchronous, active-low reset.
REQ-010 LEVEL_IN  in  N_LEVEL  asynchronous level inputs.
REQ-011 EVENT_TGL_IN  in  N_EVENT  asynchronous event toggles; one toggle equals one event.
REQ-012 BUS_IN  in  BUS_W  asynchronous configuration bus.
REQ-013 BUS_LOAD_TGL  in  1  asynchronous toggle requesting a bus update.
REQ-014 HOLD  in  1  HF_CLK-domain input; high defers commit.
REQ-015 CLR_ERR  in  1  HF_CLK-domain pulse; clears BUS_ERR.
REQ-016 NRST_sync  out  1  reset with asynchronous assert and synchronous deassert.
REQ-017 LEVEL_sync  out  N_LEVEL  synchronised levels.
REQ-018 EVENT_PULSE  out  N_EVENT  one-cycle event pulses.
REQ-019 BUS_sync  out  BUS_W  committed bus.
REQ-020 BUS_UPDATED  out  1  one-cycle pulse on each commit.
REQ-021 BUS_BUSY  out  1  high whenever the FSM state is not IDLE.
REQ-022 BUS_ERR  out  1  sticky abort flag.

Function
REQ-023 NRST_sync SHALL go low immediately when NRST is low, and SHALL go high on the SYNC_STAGES-th HF_CLK rising edge after NRST rises.
REQ-024 LEVEL_sync[i] SHALL equal LEVEL_IN[i] delayed through SYNC_STAGES flops.
REQ-025 Each event channel SHALL synchronise its toggle through SYNC_STAGES flops followed by one history flop; EVENT_PULSE[i] SHALL be the XOR of the last synchroniser stage and the history flop, giving exactly one one-cycle pulse per input toggle.
REQ-026 BUS_IN SHALL pass through SYNC_STAGES flops to produce bus_s.
REQ-027 BUS_LOAD_TGL SHALL be synchronised and edge-detected in the same way as an event channel to produce req.
REQ-028 The bus FSM SHALL have the states IDLE, QUAL, WAIT_HOLD and COMMIT.
REQ-029 IDLE: on req or pending, the FSM SHALL set sample to bus_s, set cnt to 1, set retry to 0, clear pending, and go to QUAL.
REQ-030 QUAL, bus_s equal to sample: if cnt equals STABLE_CYC-1, the FSM SHALL go to COMMIT when HOLD is low and to WAIT_HOLD when HOLD is high; otherwise it SHALL increment cnt.
REQ-031 QUAL, bus_s not equal to sample: the FSM SHALL set sample to bus_s, set cnt to 1 and increment retry; if retry reaches MAX_RETRY it SHALL set BUS_ERR and go to IDLE without committing.
REQ-032 WAIT_HOLD: the FSM SHALL remain in this state while HOLD is high and go to COMMIT on the first cycle HOLD is low; sample SHALL be frozen in this state.
REQ-033 COMMIT: the FSM SHALL load BUS_sync from sample, assert BUS_UPDATED for exactly that one cycle, and go to IDLE.
REQ-034 A req arriving in any state other than IDLE SHALL set pending; multiple such requests SHALL coalesce into one.
REQ-035 If req and CLR_ERR occur together with an abort, the abort SHALL take priority and BUS_ERR SHALL be set.
REQ-036 CLR_ERR SHALL clear BUS_ERR on the next edge and SHALL NOT affect FSM state.
REQ-037 Minimum latency SHALL be: BUS_sync changes and BUS_UPDATED rises on the STABLE_CYC-th rising edge after the edge that samples req in IDLE.
REQ-038 BUS_sync SHALL never change except in COMMIT.

Reset
REQ-039 All flops SHALL reset asynchronously on NRST low.
REQ-040 On reset: NRST_sync=0, LEVEL_sync=0, EVENT_PULSE=0, BUS_sync=BUS_RST, BUS_UPDATED=0, BUS_BUSY=0, BUS_ERR=0, state=IDLE, pending=0, all synchronisers=0.
REQ-041 Reset asserted mid-QUAL or mid-WAIT_HOLD SHALL abandon the request with no commit.

Verification (defaults: SYNC_STAGES=2, STABLE_CYC=4, MAX_RETRY=7)
REQ-042 Release NRST -> NRST_sync=1 on the 2nd edge; assert NRST between edges -> NRST_sync=0 with no clock edge.
REQ-043 Toggle EVENT_TGL_IN[0] three times, 5 cycles apart -> exactly three one-cycle EVENT_PULSE[0] pulses, each 2 edges after its toggle.
REQ-044 BUS_IN=0x15A5A5A5A5 held stable, toggle BUS_LOAD_TGL -> BUS_sync=0x15A5A5A5A5 with BUS_UPDATED on the 4th edge after req is detected; BUS_BUSY high for 4 cycles.
REQ-045 Change BUS_IN every cycle after a request -> BUS_ERR=1 after the 7th mismatch, BUS_sync unchanged, FSM in IDLE; then CLR_ERR -> BUS_ERR=0.
REQ-046 HOLD=1 during a request, stable bus -> FSM waits in WAIT_HOLD; HOLD low -> commit on the next edge; a second toggle during WAIT_HOLD -> exactly one further commit.
REQ-047 Assert NRST during QUAL -> BUS_sync=BUS_RST, no BUS_UPDATED pulse, BUS_BUSY=0.
